dual_bus_responder: RTL and testbench
=====================================

// Module: dual_bus_responder
// PURPOSE
//  Far (target) end of the two-phase dual-rail request/response bus driven by the bus2 arbiter.
//  - Detects completion of a dual-rail request word on `in`.
//  - Decodes it to binary and hands it to clocked target logic via valid/ready.
//  - Takes the binary response via valid/ready and re-encodes it as a two-phase dual-rail word on `out`.
//  - Exactly one transaction is outstanding at a time.
// PARAMETERS
//  INPUT        `size  request word width in bits (Dual elements on `in`)
//  OUTPUT       `size  response word width in bits (Dual elements on `out`)
//  SYNC_STAGES  2      synchroniser flops per rail (must be >= 2)
// PORTS
//  clk        in   1             single clock
//  reset_n    in   1             asynchronous, active-low reset
//  in         in   Dual[INPUT]   request rails from the arbiter (asynchronous to clk)
//  out        out  Dual[OUTPUT]  response rails to the arbiter
//  req_valid  out  1             decoded request available
//  req_ready  in   1             target accepts the request
//  req_data   out  INPUT         decoded request value
//  rsp_valid  in   1             target response available
//  rsp_ready  out  1             block accepts the response
//  rsp_data   in   OUTPUT        response value
//  busy       out  1             transaction in progress (state != IDLE)
//  proto_err  out  1             sticky protocol-violation flag
// BEHAVIOUR
//  Encoding: Dual = {t,f}. Bit value 1 is signalled by toggling t; bit value 0 by toggling f.
//    A word is complete when every bit has exactly one rail toggled versus the snapshot.
//  Reset (reset_n=0, async), all registers 0:
//    out rails, sync flops, prev_in snapshot, req_valid, rsp_ready, busy, proto_err.
//    State = IDLE. The arbiter is reset with the same baseline (all rails 0).
//  Sync: every in rail passes through SYNC_STAGES flops; only synchronised rails (sin) are used.
//  chg[i]  = sin[i] ^ prev_in[i] (per rail).
//  done    = all bits have exactly one rail changed.
//  dbl     = any bit has both rails changed.
//  IDLE:
//    done && !dbl -> capture req_data[i] = chg[i].t, prev_in <= sin, go to PRESENT.
//    Partial words wait indefinitely; rail skew across cycles is legal.
//  PRESENT:
//    req_valid=1; req_data held stable until req_ready.
//    req_valid && req_ready -> go to SERVE.
//  SERVE:
//    rsp_ready=1.
//    rsp_valid && rsp_ready -> for each bit toggle out[i].t if rsp_data[i]=1, else out[i].f.
//    The toggle is registered, so out changes 1 cycle after the handshake. Go to IDLE.
//  Latency:
//    Last request rail toggle -> req_valid: SYNC_STAGES+1 cycles after it reaches the first sync flop.
//    Response handshake -> out toggle: 1 cycle.
//  Violations (each sets proto_err, which stays 1 until reset):
//    - dbl in IDLE: word is not captured; proto_err=1; block stays in IDLE; snapshot is not updated.
//    - any chg in PRESENT/SERVE (arbiter sent before response): proto_err=1; the change is ignored
//      until return to IDLE, then evaluated normally.
//  Simultaneous events:
//    - A response handshake and a new request completing in the same cycle cannot both occur
//      (the new request is only evaluated in IDLE).
//    - A back-to-back request becomes visible no earlier than the cycle after return to IDLE.
//  Reset mid-operation: immediate async clear; any in-flight request or response is dropped.
//  out rails are only ever changed by one registered update per transaction (glitch-free per rail).
// STRUCTURE
//  Shared package/defs.svh:
//    - Dual typedef {t,f}.
//    - `size` constant.
//    - State enum {IDLE,PRESENT,SERVE} typedef.
//  Sub-module dual_capture #(INPUT,SYNC_STAGES):
//    - rail synchronisers, snapshot, done/dbl/decode logic.
//    - Ports: clk, reset_n, in, take, done, dbl, any_chg, value.
//  Top: FSM, req/rsp handshakes, out encoder register.
// TESTING (INPUT=OUTPUT=4, SYNC_STAGES=2)
//  1 Reset: pulse reset_n low -> out=all {0,0}, req_valid=0, rsp_ready=0, busy=0, proto_err=0.
//  2 Request 4'b1010 (toggle in[3].t,in[2].f,in[1].t,in[0].f in one cycle) -> req_valid 3 cycles
//    later, req_data=4'b1010; req_ready held low 5 cycles -> req_valid and req_data stable.
//  3 Response 4'b0110 accepted -> next cycle out[2].t,out[1].t,out[3].f,out[0].f toggled, others
//    unchanged; busy=0. Second request 4'b1010 -> t rails toggle back to 0, decode still 4'b1010.
//  4 Skew: toggle the 4 bits of 4'b0011 one per cycle -> exactly one req_valid pulse train,
//    data 4'b0011, no earlier partial capture.
//  5 Toggle both in[0].t and in[0].f plus valid rails on the other bits -> proto_err=1, no
//    req_valid; extra toggle of in[2] during SERVE -> proto_err stays 1.
//  6 Assert reset_n low while in SERVE -> out, busy, rsp_ready=0 immediately; a fresh request
//    4'b0101 after release decodes correctly.

Source files
------------

// File: rtl/dual_bus_responder_pkg.sv
// Shared definitions for the dual-rail bus responder: rail pair type,
// default word width, FSM state encoding and the rail toggle helper.
package dual_bus_responder_pkg;

  // Default request/response word width in bits
  localparam int SIZE = 4;

  // One dual-rail bit: a toggle on t carries a 1, a toggle on f carries a 0
  typedef struct packed {
    logic t;
    logic f;
  } dual_t;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t PRESENT = 2'd1;
  localparam state_t SERVE   = 2'd2;

  // Return the rail pair with the rail matching bit_val flipped
  function automatic dual_t dual_toggle(input dual_t cur, input logic bit_val);
    dual_t nxt;
    nxt = cur;
    if (bit_val) begin
      nxt.t = ~cur.t;
    end else begin
      nxt.f = ~cur.f;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dual_capture.sv
// Request side of the responder: synchronises every incoming rail, keeps the
// snapshot of the last accepted word and detects complete / illegal words.
module dual_capture
  import dual_bus_responder_pkg::*;
#(
  parameter int INPUT       = SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  dual_t [INPUT-1:0]      in,
  input  logic                   take,
  output logic                   done,
  output logic                   dbl,
  output logic                   any_chg,
  output logic [INPUT-1:0]       value
);

  localparam int W = 2 * INPUT;

  logic [W-1:0] sync_r [SYNC_STAGES];
  logic [W-1:0] sin_s;
  logic [W-1:0] prev_r;
  logic [W-1:0] chg_s;

  // Shift every rail through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {W{1'b0}};
      end
    end else begin
      sync_r[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sin_s = sync_r[SYNC_STAGES-1];
  assign chg_s = sin_s ^ prev_r;

  // Snapshot the synchronised rails when a word is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= {W{1'b0}};
    end else if (take) begin
      prev_r <= sin_s;
    end else begin
      prev_r <= prev_r;
    end
  end

  // Completion, double-toggle detection and decode of the t rails
  always_comb begin
    done  = 1'b1;
    dbl   = 1'b0;
    value = {INPUT{1'b0}};
    for (int i = 0; i < INPUT; i++) begin
      done     = done & (chg_s[2*i+1] ^ chg_s[2*i]);
      dbl      = dbl  | (chg_s[2*i+1] & chg_s[2*i]);
      value[i] = chg_s[2*i+1];
    end
  end

  assign any_chg = |chg_s;

endmodule

// File: rtl/dual_bus_responder.sv
// Target end of the two-phase dual-rail bus: decodes one request word at a
// time, hands it to clocked logic via valid/ready, and re-encodes the
// response as a single registered toggle per bit on the out rails.
module dual_bus_responder
  import dual_bus_responder_pkg::*;
#(
  parameter int INPUT       = SIZE,
  parameter int OUTPUT      = SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  dual_t [INPUT-1:0]   in,
  output dual_t [OUTPUT-1:0]  out,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [INPUT-1:0]    req_data,
  input  logic                rsp_valid,
  output logic                rsp_ready,
  input  logic [OUTPUT-1:0]   rsp_data,
  output logic                busy,
  output logic                proto_err
);

  state_t              state_r;
  dual_t [OUTPUT-1:0]  out_r;
  dual_t [OUTPUT-1:0]  out_nxt_s;
  logic                req_valid_r;
  logic [INPUT-1:0]    req_data_r;
  logic                rsp_ready_r;
  logic                busy_r;
  logic                proto_err_r;

  logic                take_s;
  logic                cap_done_s;
  logic                cap_dbl_s;
  logic                cap_any_chg_s;
  logic [INPUT-1:0]    cap_value_s;
  logic                req_hs_s;
  logic                rsp_hs_s;

  dual_capture #(
    .INPUT       (INPUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_capture (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .take    (take_s),
    .done    (cap_done_s),
    .dbl     (cap_dbl_s),
    .any_chg (cap_any_chg_s),
    .value   (cap_value_s)
  );

  // Handshake qualifiers; a new word is only looked at while idle
  always_comb begin
    take_s   = (state_r == IDLE) && cap_done_s && !cap_dbl_s;
    req_hs_s = req_valid_r && req_ready;
    rsp_hs_s = rsp_valid && rsp_ready_r;
  end

  // Next out rails: one toggle per bit, rail chosen by the response bit
  always_comb begin
    out_nxt_s = out_r;
    for (int i = 0; i < OUTPUT; i++) begin
      out_nxt_s[i] = dual_toggle(out_r[i], rsp_data[i]);
    end
  end

  // Transaction FSM, handshake flags, sticky error and out encoder register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      out_r       <= {(2*OUTPUT){1'b0}};
      req_valid_r <= 1'b0;
      req_data_r  <= {INPUT{1'b0}};
      rsp_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            state_r     <= PRESENT;
            req_valid_r <= 1'b1;
            req_data_r  <= cap_value_s;
            busy_r      <= 1'b1;
          end else if (cap_dbl_s) begin
            proto_err_r <= 1'b1;
          end
        end
        PRESENT: begin
          // Arbiter must not start a new word before our response
          if (cap_any_chg_s) begin
            proto_err_r <= 1'b1;
          end
          if (req_hs_s) begin
            state_r     <= SERVE;
            req_valid_r <= 1'b0;
            rsp_ready_r <= 1'b1;
          end
        end
        SERVE: begin
          if (cap_any_chg_s) begin
            proto_err_r <= 1'b1;
          end
          if (rsp_hs_s) begin
            state_r     <= IDLE;
            out_r       <= out_nxt_s;
            rsp_ready_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
          rsp_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign req_valid = req_valid_r;
  assign req_data  = req_data_r;
  assign rsp_ready = rsp_ready_r;
  assign busy      = busy_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_dual_bus_responder.sv
// Scoreboard bench for dual_bus_responder (INPUT=OUTPUT=4, SYNC_STAGES=2).
// Stimulus pushes expected request words and out-rail words into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dual_bus_responder;
  import dual_bus_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  dual_t [3:0] in_v;
  dual_t [3:0] out_v;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic        busy;
  logic        proto_err;
  logic [7:0]  out_flat;

  int          checks = 0;
  int          errors = 0;
  int          req_hs_cnt = 0;
  int          lat;
  int          hs_before;
  logic [3:0]  req_q [$];
  logic [7:0]  out_q [$];
  logic [7:0]  out_model = 8'h00;
  logic [7:0]  last_out = 8'h00;

  assign out_flat = out_v;

  dual_bus_responder #(.INPUT(4), .OUTPUT(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in_v),
    .out       (out_v),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {7'd0, act}, {7'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare accepted requests and every out-rail change
  always @(negedge clk) begin
    if (!reset_n) begin
      last_out = out_flat;
    end else begin
      if (req_valid && req_ready) begin
        req_hs_cnt++;
        if (req_q.size() == 0) begin
          check("req_unexpected", {4'h0, req_data}, 8'hff);
        end else begin
          check("req_data", {4'h0, req_data}, {4'h0, req_q.pop_front()});
        end
      end
      if (out_flat !== last_out) begin
        if (out_q.size() == 0) begin
          check("out_unexpected", out_flat, last_out);
        end else begin
          check("out_rails", out_flat, out_q.pop_front());
        end
        last_out = out_flat;
      end
    end
  end

  task automatic do_reset();
    in_v    = '0;
    reset_n = 1'b0;
    #1;
    out_model = 8'h00;
    req_q.delete();
    out_q.delete();
    check("rst_out", out_flat, 8'h00);
    check1("rst_req_valid", req_valid, 1'b0);
    check1("rst_rsp_ready", rsp_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_proto_err", proto_err, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w[i]) in_v[i].t = ~in_v[i].t;
      else      in_v[i].f = ~in_v[i].f;
    end
    req_q.push_back(w);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check1("req_valid_seen", req_valid, 1'b1);
  endtask

  task automatic accept(input logic [3:0] w, input int stall);
    for (int k = 0; k < stall; k++) begin
      tick();
      check1("stall_valid", req_valid, 1'b1);
      check("stall_data", {4'h0, req_data}, {4'h0, w});
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [3:0] d);
    int n;
    n = 0;
    while (!rsp_ready && n < 20) begin
      tick();
      n++;
    end
    check1("rsp_ready_seen", rsp_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (d[i]) out_model[2*i+1] = ~out_model[2*i+1];
      else      out_model[2*i]   = ~out_model[2*i];
    end
    out_q.push_back(out_model);
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_v      = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 4'h0;
    #2;
    // 1: reset state
    do_reset();

    // 2: request 1010, 3-cycle latency, 5-cycle stall
    send_word(4'b1010);
    wait_req(lat);
    check("req_latency", lat[7:0], 8'd3);
    accept(4'b1010, 5);

    // 3: response 0110, then a second 1010 that returns the t rails to 0
    respond(4'b0110);
    check1("busy_after_rsp", busy, 1'b0);
    tick();
    check("out_0110", out_flat, 8'b01101001);
    send_word(4'b1010);
    wait_req(lat);
    accept(4'b1010, 0);
    respond(4'b1001);
    tick();

    // 4: skewed word 0011, one rail per cycle
    hs_before = req_hs_cnt;
    in_v[0].t = ~in_v[0].t;
    repeat (3) tick();
    check1("skew_partial0", req_valid, 1'b0);
    in_v[1].t = ~in_v[1].t;
    repeat (3) tick();
    check1("skew_partial1", req_valid, 1'b0);
    in_v[2].f = ~in_v[2].f;
    repeat (3) tick();
    check1("skew_partial2", req_valid, 1'b0);
    in_v[3].f = ~in_v[3].f;
    req_q.push_back(4'b0011);
    wait_req(lat);
    accept(4'b0011, 1);
    respond(4'b1111);
    repeat (3) tick();
    check("skew_one_word", hs_before[7:0] + 8'd1, req_hs_cnt[7:0]);

    // 5: double toggle on bit 0, then repair and late toggle in SERVE
    in_v[0].t = ~in_v[0].t;
    in_v[0].f = ~in_v[0].f;
    for (int i = 1; i < 4; i++) in_v[i].t = ~in_v[i].t;
    repeat (5) tick();
    check1("dbl_err", proto_err, 1'b1);
    check1("dbl_no_valid", req_valid, 1'b0);
    check1("dbl_idle", busy, 1'b0);
    in_v[0].t = ~in_v[0].t;
    req_q.push_back(4'b1110);
    wait_req(lat);
    accept(4'b1110, 0);
    in_v[2].t = ~in_v[2].t;
    repeat (3) tick();
    check1("serve_chg_err", proto_err, 1'b1);
    check1("serve_busy", busy, 1'b1);
    respond(4'b1001);
    repeat (4) tick();
    check1("err_sticky", proto_err, 1'b1);
    check1("partial_after_serve", req_valid, 1'b0);

    // 6: reset while in SERVE, then a fresh 0101
    do_reset();
    send_word(4'b1100);
    wait_req(lat);
    accept(4'b1100, 0);
    check1("pre_reset_serve", rsp_ready, 1'b1);
    do_reset();
    send_word(4'b0101);
    wait_req(lat);
    accept(4'b0101, 0);
    respond(4'b0011);
    tick();
    check("out_after_reset", out_flat, 8'b01011010);
    check1("busy_end", busy, 1'b0);

    repeat (3) tick();
    check("req_q_empty", req_q.size(), 8'd0);
    check("out_q_empty", out_q.size(), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
